// File: rtl/cnn_layer_ctrl.sv
// Layer sequencer: runs the ZPAD/IM2C/DOTP/BIAS stage chain, then streams the captured bias result.
// Optional feature: define CNN_RELU_EN to clamp negative output words to zero on the read path.
module cnn_layer_ctrl #(
    parameter int          DATA_LEN    = 16,
    parameter int          CH_OUT      = 32,
    parameter int          PIX         = 12,
    parameter logic [3:0]  AFFINE_ID   = 4'd5,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load,
    input  logic [3:0]                        cs_layer,
    output logic [3:0]                        stg_start,
    input  logic [3:0]                        stg_done,
    output logic [3:0]                        stg_layer,
    input  logic [PIX*CH_OUT*DATA_LEN-1:0]    bias_d,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CH_OUT*DATA_LEN-1:0]        out_data,
    output logic [$clog2(PIX)-1:0]            out_idx,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic [2:0]                        cs_out
);

    localparam int IDX_W = $clog2(PIX);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam int ROW_W = CH_OUT * DATA_LEN;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ZPAD = 3'd1,
        S_IM2C = 3'd2,
        S_DOTP = 3'd3,
        S_BIAS = 3'd4,
        S_STRM = 3'd5,
        S_FINI = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    state_t                          state;
    logic [TMO_W-1:0]                tmo_cnt;
    logic [PIX*CH_OUT*DATA_LEN-1:0]  bias_buf;
    logic                            stage_done;
    logic [ROW_W-1:0]                out_row;
    logic [DATA_LEN-1:0]             word;

    assign cs_out = state;

    // Only the done bit belonging to the active stage matters.
    always_comb begin
        stage_done = 1'b0;
        case (state)
            S_ZPAD:  stage_done = stg_done[0];
            S_IM2C:  stage_done = stg_done[1];
            S_DOTP:  stage_done = stg_done[2];
            S_BIAS:  stage_done = stg_done[3];
            default: stage_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            bias_buf  <= '0;
            stg_start <= '0;
            stg_layer <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            stg_start <= '0;
            done      <= 1'b0;
            case (state)
                S_IDLE, S_ERR: begin
                    if (load) begin
                        stg_layer <= cs_layer;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        tmo_cnt   <= '0;
                        if (cs_layer == AFFINE_ID) begin
                            state     <= S_DOTP;
                            stg_start <= 4'b0100;
                        end else begin
                            state     <= S_ZPAD;
                            stg_start <= 4'b0001;
                        end
                    end
                end
                S_ZPAD, S_IM2C, S_DOTP, S_BIAS: begin
                    // A done arriving on the expiry cycle still advances the chain.
                    if (stage_done) begin
                        tmo_cnt <= '0;
                        case (state)
                            S_ZPAD: begin
                                state     <= S_IM2C;
                                stg_start <= 4'b0010;
                            end
                            S_IM2C: begin
                                state     <= S_DOTP;
                                stg_start <= 4'b0100;
                            end
                            S_DOTP: begin
                                state     <= S_BIAS;
                                stg_start <= 4'b1000;
                            end
                            default: begin
                                state     <= S_STRM;
                                bias_buf  <= bias_d;
                                out_valid <= 1'b1;
                                out_idx   <= '0;
                                out_last  <= 1'b0;
                            end
                        endcase
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_STRM: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= S_FINI;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_idx  <= out_idx + 1'b1;
                            out_last <= (out_idx == IDX_W'(PIX - 2));
                        end
                    end
                end
                S_FINI: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read path straight off the captured buffer, so no extra beat latency.
    always_comb begin
        out_row  = bias_buf[int'(out_idx) * ROW_W +: ROW_W];
        out_data = '0;
        word     = '0;
        for (int c = 0; c < CH_OUT; c++) begin
            word = out_row[c*DATA_LEN +: DATA_LEN];
`ifdef CNN_RELU_EN
            if (word[DATA_LEN-1]) begin
                word = '0;
            end
`endif
            out_data[c*DATA_LEN +: DATA_LEN] = word;
        end
    end

endmodule

// File: tb/tb_cnn_layer_ctrl.sv
// Bench for cnn_layer_ctrl: table of layer runs plus timeout and mid-stream reset sequences.
module tb_cnn_layer_ctrl;

    localparam int         DATA_LEN    = 16;
    localparam int         CH_OUT      = 32;
    localparam int         PIX         = 12;
    localparam logic [3:0] AFFINE_ID   = 4'd5;
    localparam int         TIMEOUT_CYC = 1024;
    localparam int         IDX_W       = $clog2(PIX);
    localparam int         ROW_W       = CH_OUT * DATA_LEN;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           load;
    logic [3:0]                     cs_layer;
    logic [3:0]                     stg_start;
    logic [3:0]                     stg_done;
    logic [3:0]                     stg_layer;
    logic [PIX*CH_OUT*DATA_LEN-1:0] bias_d;
    logic                           out_valid;
    logic                           out_ready;
    logic [ROW_W-1:0]               out_data;
    logic [IDX_W-1:0]               out_idx;
    logic                           out_last;
    logic                           busy;
    logic                           done;
    logic                           err;
    logic [2:0]                     cs_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DATA_LEN-1:0] ref_words [PIX][CH_OUT];

    typedef struct {
        logic [3:0] layer;
        int         d0, d1, d2, d3;
        int         ready_mode;
        int         bias_mode;
        logic [3:0] exp_first_start;
        int         exp_pulses;
    } vec_t;

    vec_t vecs [12];

    cnn_layer_ctrl #(
        .DATA_LEN(DATA_LEN), .CH_OUT(CH_OUT), .PIX(PIX),
        .AFFINE_ID(AFFINE_ID), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .cs_layer(cs_layer),
        .stg_start(stg_start), .stg_done(stg_done), .stg_layer(stg_layer),
        .bias_d(bias_d), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .done(done), .err(err), .cs_out(cs_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_LEN-1:0] reluModel(input logic [DATA_LEN-1:0] w);
`ifdef CNN_RELU_EN
        return ($signed(w) < 0) ? '0 : w;
`else
        return w;
`endif
    endfunction

    function automatic logic [ROW_W-1:0] expRow(input int p);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int c = 0; c < CH_OUT; c++) r[c*DATA_LEN +: DATA_LEN] = reluModel(ref_words[p][c]);
        return r;
    endfunction

    task automatic fillBias(input int mode);
        for (int p = 0; p < PIX; p++)
            for (int c = 0; c < CH_OUT; c++)
                ref_words[p][c] = DATA_LEN'($urandom);
        if (mode == 1) begin
            ref_words[0][0] = 16'hFFF0;
            ref_words[0][1] = 16'h0010;
        end
        for (int p = 0; p < PIX; p++)
            for (int c = 0; c < CH_OUT; c++)
                bias_d[(p*CH_OUT + c)*DATA_LEN +: DATA_LEN] = ref_words[p][c];
    endtask

    // One full layer run; the model knows the stage list, latency and beat contents.
    task automatic applyStimulus(input vec_t v);
        int stages[$];
        int dly[4];
        int l0, fb, lat_exp, pulses, beats, guard, t;
        logic r;
        logic [3:0] noise;
        dly[0] = v.d0; dly[1] = v.d1; dly[2] = v.d2; dly[3] = v.d3;
        if (v.layer == AFFINE_ID) stages = '{2, 3};
        else stages = '{0, 1, 2, 3};
        fillBias(v.bias_mode);
        @(negedge clk);
        load = 1'b1;
        cs_layer = v.layer;
        @(negedge clk);
        l0 = cyc;
        load = 1'b0;
        checkOutput("first_start", ROW_W'(stg_start), ROW_W'(v.exp_first_start));
        checkOutput("err_cleared", ROW_W'(err), '0);
        checkOutput("busy_run", ROW_W'(busy), 1);
        lat_exp = 1;
        pulses = 0;
        foreach (stages[i]) begin
            lat_exp += dly[stages[i]] + 1;
            for (int k = 0; k <= dly[stages[i]]; k++) begin
                checkOutput("stage_state", ROW_W'(cs_out), ROW_W'(stages[i] + 1));
                checkOutput("stage_start", ROW_W'(stg_start), (k == 0) ? ROW_W'(4'b1 << stages[i]) : '0);
                if (stg_start != 4'b0) pulses++;
                noise = 4'($urandom);
                noise[stages[i]] = (k == dly[stages[i]]);
                stg_done = noise;
                load = ($urandom_range(0, 3) == 0);
                cs_layer = 4'($urandom);
                @(negedge clk);
            end
        end
        stg_done = '0;
        checkOutput("pulse_count", ROW_W'(pulses), ROW_W'(v.exp_pulses));
        bias_d = {PIX*CH_OUT{16'h5A5A}} ^ bias_d ^ {PIX*CH_OUT/2{$urandom}};
        beats = 0;
        guard = 0;
        t = 0;
        fb = -1;
        while (beats < PIX && guard < PIX * 8) begin
            checkOutput("strm_valid", ROW_W'(out_valid), 1);
            checkOutput("strm_idx", ROW_W'(out_idx), ROW_W'(beats));
            checkOutput("strm_last", ROW_W'(out_last), ROW_W'(beats == PIX - 1));
            checkOutput("strm_data", out_data, expRow(beats));
            if (v.bias_mode == 1 && beats == 0) begin
`ifdef CNN_RELU_EN
                checkOutput("relu_w00", ROW_W'(out_data[15:0]), ROW_W'(16'h0000));
`else
                checkOutput("relu_w00", ROW_W'(out_data[15:0]), ROW_W'(16'hFFF0));
`endif
                checkOutput("relu_w01", ROW_W'(out_data[31:16]), ROW_W'(16'h0010));
            end
            case (v.ready_mode)
                0:       r = 1'b1;
                1:       r = (t % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            load = ($urandom_range(0, 3) == 0);
            t++;
            if (r) begin
                if (beats == 0) fb = cyc + 1;
                beats++;
            end
            @(negedge clk);
            guard++;
        end
        load = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        checkOutput("beat_count", ROW_W'(beats), ROW_W'(PIX));
        if (v.ready_mode != 2) checkOutput("latency", ROW_W'(fb - l0), ROW_W'(lat_exp));
        checkOutput("fini_done", ROW_W'(done), 1);
        checkOutput("fini_state", ROW_W'(cs_out), 6);
        checkOutput("fini_valid", ROW_W'(out_valid), 0);
        @(negedge clk);
        checkOutput("done_pulse", ROW_W'(done), 0);
        checkOutput("idle_busy", ROW_W'(busy), 0);
        checkOutput("idle_state", ROW_W'(cs_out), 0);
        checkOutput("stg_layer_held", ROW_W'(stg_layer), ROW_W'(v.layer));
        out_ready = 1'b0;
    endtask

    task automatic timeoutSequence();
        int n;
        logic [3:0] noise;
        fillBias(0);
        @(negedge clk);
        load = 1'b1;
        cs_layer = AFFINE_ID;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (cs_out == 3'd3 && n < TIMEOUT_CYC + 8) begin
            noise = 4'($urandom);
            noise[2] = 1'b0;
            stg_done = noise;
            n++;
            @(negedge clk);
        end
        stg_done = '0;
        checkOutput("tmo_cycles", ROW_W'(n), ROW_W'(TIMEOUT_CYC));
        checkOutput("tmo_err", ROW_W'(err), 1);
        checkOutput("tmo_state", ROW_W'(cs_out), 7);
        checkOutput("tmo_busy", ROW_W'(busy), 0);
        repeat (5) @(negedge clk);
        checkOutput("err_sticky", ROW_W'(err), 1);
        checkOutput("err_no_start", ROW_W'(stg_start), 0);
        checkOutput("err_no_valid", ROW_W'(out_valid), 0);
    endtask

    task automatic resetSequence();
        int g;
        int done_seen;
        fillBias(0);
        @(negedge clk);
        load = 1'b1;
        cs_layer = 4'd3;
        @(negedge clk);
        load = 1'b0;
        g = 0;
        while (!out_valid && g < 40) begin
            stg_done = stg_start;
            g++;
            @(negedge clk);
        end
        stg_done = '0;
        out_ready = 1'b1;
        while (out_idx != IDX_W'(5) && g < 80) begin
            g++;
            @(negedge clk);
        end
        checkOutput("rst_reach_idx5", ROW_W'(out_idx), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_valid", ROW_W'(out_valid), 0);
        checkOutput("rst_state", ROW_W'(cs_out), 0);
        checkOutput("rst_idx", ROW_W'(out_idx), 0);
        checkOutput("rst_busy", ROW_W'(busy), 0);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || out_valid) done_seen++;
            @(negedge clk);
        end
        checkOutput("rst_no_done", ROW_W'(done_seen), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; cs_layer = '0; stg_done = '0; out_ready = 1'b0; bias_d = '0;

        vecs[0] = '{4'd1, 3, 3, 3, 3, 0, 0, 4'b0001, 4};
        vecs[1] = '{AFFINE_ID, 3, 3, 3, 3, 0, 0, 4'b0100, 2};
        vecs[2] = '{4'd2, 0, 0, 0, 0, 1, 0, 4'b0001, 4};
        vecs[3] = '{4'd1, 0, 0, 0, 0, 0, 1, 4'b0001, 4};
        vecs[4] = '{AFFINE_ID, 0, 0, 1, 2, 2, 0, 4'b0100, 2};
        vecs[5] = '{4'd7, TIMEOUT_CYC - 1, 0, 2, 0, 2, 0, 4'b0001, 4};
        vecs[6] = '{4'd15, 1, 4, 0, 7, 1, 0, 4'b0001, 4};
        vecs[7] = '{AFFINE_ID, 0, 0, TIMEOUT_CYC - 1, TIMEOUT_CYC - 1, 0, 1, 4'b0100, 2};
        for (int i = 8; i < 12; i++) begin
            vecs[i].layer = ($urandom_range(0, 2) == 0) ? AFFINE_ID : 4'($urandom);
            vecs[i].d0 = $urandom_range(0, 6);
            vecs[i].d1 = $urandom_range(0, 6);
            vecs[i].d2 = $urandom_range(0, 6);
            vecs[i].d3 = $urandom_range(0, 6);
            vecs[i].ready_mode = 2;
            vecs[i].bias_mode = 0;
            vecs[i].exp_first_start = (vecs[i].layer == AFFINE_ID) ? 4'b0100 : 4'b0001;
            vecs[i].exp_pulses = (vecs[i].layer == AFFINE_ID) ? 2 : 4;
        end

        repeat (2) @(negedge clk);
        checkOutput("reset_state", ROW_W'(cs_out), 0);
        checkOutput("reset_valid", ROW_W'(out_valid), 0);
        checkOutput("reset_busy", ROW_W'(busy), 0);
        checkOutput("reset_done", ROW_W'(done), 0);
        checkOutput("reset_err", ROW_W'(err), 0);
        checkOutput("reset_start", ROW_W'(stg_start), 0);
        checkOutput("reset_layer", ROW_W'(stg_layer), 0);
        checkOutput("reset_idx", ROW_W'(out_idx), 0);
        checkOutput("reset_last", ROW_W'(out_last), 0);
        checkOutput("reset_data", out_data, '0);
        rst = 1'b0;

        timeoutSequence();
        for (int i = 0; i < 12; i++) begin
            $display("[TB] vector %0d layer=%0d", i, vecs[i].layer);
            applyStimulus(vecs[i]);
            if (i == 3) resetSequence();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
